// File: rtl/flappy_game_engine.sv
// Flappy game engine: once per frame_tick it advances bird physics, scrolls
// and respawns pipes, detects collisions and keeps score. All object
// coordinates are registered for the downstream VGA compositing stage.
module flappy_game_engine #(
  parameter int         BIRD_X       = 100,
  parameter int         BIRD_SIZE    = 30,
  parameter int         START_Y      = 200,
  parameter int         GRAVITY      = 1,
  parameter int         FLAP_VEL     = 8,
  parameter int         MAX_FALL     = 10,
  parameter int         GROUND_Y     = 460,
  parameter int         NUM_PIPES    = 4,
  parameter int         PIPE_W       = 50,
  parameter int         PIPE_SPACING = 160,
  parameter int         PIPE_X0      = 640,
  parameter int         SCROLL       = 1,
  parameter int         GAP_H        = 100,
  parameter int         GAP_MIN      = 40,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     flap_btn,
  output logic [8:0]               bird_y,
  output logic [NUM_PIPES*11-1:0]  pipe_x_flat,
  output logic [NUM_PIPES*9-1:0]   gap_top_flat,
  output logic [7:0]               score,
  output logic [1:0]               state,
  output logic                     game_over
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_DYING = 2'd2, S_OVER = 2'd3} state_e;

  localparam logic        [10:0] PX_SCROLL  = 11'(SCROLL);
  localparam logic        [10:0] PX_RESPAWN = 11'(NUM_PIPES*PIPE_SPACING - SCROLL);
  localparam logic        [11:0] PIPE_W12   = 12'(PIPE_W);
  localparam logic        [11:0] BIRD_X12   = 12'(BIRD_X);
  localparam logic        [11:0] BIRD_R12   = 12'(BIRD_X + BIRD_SIZE);
  localparam logic        [9:0]  Y_SIZE10   = 10'(BIRD_SIZE);
  localparam logic        [9:0]  GAP_H10    = 10'(GAP_H);
  localparam logic        [8:0]  GT_MIN9    = 9'(GAP_MIN);
  localparam logic        [8:0]  Y_START9   = 9'(START_Y);
  localparam logic signed [10:0] Y_GND_TOP  = 11'(GROUND_Y - BIRD_SIZE);
  localparam logic signed [5:0]  VEL_FLAP   = 6'(-FLAP_VEL);
  localparam logic signed [6:0]  VEL_G7     = 7'(GRAVITY);
  localparam logic signed [6:0]  VEL_MAX7   = 7'(MAX_FALL);

  function automatic logic [10:0] init_px(input int i);
    return 11'(PIPE_X0 + i*PIPE_SPACING);
  endfunction

  function automatic logic [8:0] init_gt(input int i);
    return 9'(GAP_MIN + 20*i);
  endfunction

  state_e                        state_q, state_d;
  logic                          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic                          flap_pending_q, flap_pending_d;
  logic [7:0]                    lfsr_q, lfsr_d;
  logic [8:0]                    bird_y_q, bird_y_d;
  logic signed [5:0]             vel_q, vel_d;
  logic [7:0]                    score_q, score_d;
  logic [NUM_PIPES-1:0][10:0]    pipe_x_q, pipe_x_d;
  logic [NUM_PIPES-1:0][8:0]     gap_top_q, gap_top_d;

  logic                          flap_edge, flap_now, use_flap;
  logic signed [6:0]             vel_inc;
  logic signed [5:0]             vel_grav, vel_n;
  logic signed [10:0]            y_s;
  logic [8:0]                    y_next;
  logic                          hit_ground, collide, respawned;
  logic [NUM_PIPES-1:0][10:0]    px_n;
  logic [NUM_PIPES-1:0][8:0]     gt_n;
  logic [7:0]                    score_n;
  logic                          do_play, do_dying, do_reinit;

  // State and datapath registers; async reset loads the game-init picture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      flap_pending_q <= 1'b0;
      lfsr_q         <= LFSR_SEED;
      bird_y_q       <= Y_START9;
      vel_q          <= '0;
      score_q        <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipe_x_q[i]  <= init_px(i);
        gap_top_q[i] <= init_gt(i);
      end
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      flap_pending_q <= flap_pending_d;
      lfsr_q         <= lfsr_d;
      bird_y_q       <= bird_y_d;
      vel_q          <= vel_d;
      score_q        <= score_d;
      pipe_x_q       <= pipe_x_d;
      gap_top_q      <= gap_top_d;
    end
  end

  // Button synchroniser, rising-edge latch until the next frame, free-running LFSR
  always_comb begin
    sync1_d        = flap_btn;
    sync2_d        = sync1_q;
    prev_d         = sync2_q;
    flap_edge      = sync2_q & ~prev_q;
    flap_now       = flap_pending_q | flap_edge;
    flap_pending_d = frame_tick ? 1'b0 : flap_now;
    lfsr_d         = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Bird physics: velocity update, ceiling clamp, ground clamp
  always_comb begin
    use_flap = flap_now && (state_q != S_DYING);
    vel_inc  = $signed({vel_q[5], vel_q}) + VEL_G7;
    vel_grav = (vel_inc > VEL_MAX7) ? VEL_MAX7[5:0] : vel_inc[5:0];
    vel_n    = use_flap ? VEL_FLAP : vel_grav;
    y_s      = $signed({2'b00, bird_y_q}) + $signed({{5{vel_n[5]}}, vel_n});
    hit_ground = (y_s >= Y_GND_TOP);
    if (hit_ground)    y_next = Y_GND_TOP[8:0];
    else if (y_s[10])  y_next = '0;
    else               y_next = y_s[8:0];
  end

  // Pipe scroll with single lowest-index respawn per frame, and pass scoring
  always_comb begin
    px_n      = pipe_x_q;
    gt_n      = gap_top_q;
    score_n   = score_q;
    respawned = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (pipe_x_q[i] < PX_SCROLL) begin
        // A second pipe at the left edge waits one frame rather than wrapping below zero
        if (!respawned) begin
          px_n[i]   = pipe_x_q[i] + PX_RESPAWN;
          gt_n[i]   = GT_MIN9 + {2'b00, lfsr_q[6:0]};
          respawned = 1'b1;
        end
      end else begin
        px_n[i] = pipe_x_q[i] - PX_SCROLL;
        if ((({1'b0, pipe_x_q[i]} + PIPE_W12) >= BIRD_X12) &&
            (({1'b0, px_n[i]} + PIPE_W12) < BIRD_X12) && (score_n != 8'hFF))
          score_n = score_n + 8'd1;
      end
    end
  end

  // Collision on post-update bird and pipe positions
  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (({1'b0, px_n[i]} <= BIRD_R12) && (({1'b0, px_n[i]} + PIPE_W12) >= BIRD_X12) &&
          ((y_next < gt_n[i]) ||
           (({1'b0, y_next} + Y_SIZE10) > ({1'b0, gt_n[i]} + GAP_H10))))
        collide = 1'b1;
    end
  end

  // Next-state logic; ground takes priority over a pipe hit
  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        S_IDLE:  if (flap_now) state_d = hit_ground ? S_OVER : (collide ? S_DYING : S_PLAY);
        S_PLAY:  state_d = hit_ground ? S_OVER : (collide ? S_DYING : S_PLAY);
        S_DYING: if (hit_ground) state_d = S_OVER;
        S_OVER:  if (flap_now) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Per-frame register updates; everything holds between ticks
  always_comb begin
    do_play   = frame_tick && ((state_q == S_PLAY) || ((state_q == S_IDLE) && flap_now));
    do_dying  = frame_tick && (state_q == S_DYING);
    do_reinit = frame_tick && (state_q == S_OVER) && flap_now;
    bird_y_d  = bird_y_q;
    vel_d     = vel_q;
    score_d   = score_q;
    pipe_x_d  = pipe_x_q;
    gap_top_d = gap_top_q;
    if (do_play) begin
      bird_y_d  = y_next;
      vel_d     = vel_n;
      score_d   = score_n;
      pipe_x_d  = px_n;
      gap_top_d = gt_n;
    end else if (do_dying) begin
      bird_y_d  = y_next;
      vel_d     = vel_n;
    end else if (do_reinit) begin
      bird_y_d  = Y_START9;
      vel_d     = '0;
      score_d   = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipe_x_d[i]  = init_px(i);
        gap_top_d[i] = init_gt(i);
      end
    end
  end

  // Output decode
  always_comb begin
    state     = state_q;
    game_over = (state_q == S_OVER);
    bird_y    = bird_y_q;
    score     = score_q;
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_flat
    assign pipe_x_flat[11*g +: 11] = pipe_x_q[g];
    assign gap_top_flat[9*g +: 9]  = gap_top_q[g];
  end

endmodule

// File: tb/tb_flappy_game_engine.sv
// Bench for flappy_game_engine: a behavioural game model predicts every
// frame's outputs into a scoreboard queue, checked after each tick edge.
module tb_flappy_game_engine;
  logic        clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, flap_btn = 1'b0;
  logic [8:0]  bird_y;
  logic [43:0] pipe_x_flat;
  logic [35:0] gap_top_flat;
  logic [7:0]  score;
  logic [1:0]  state;
  logic        game_over;

  flappy_game_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .flap_btn(flap_btn),
    .bird_y(bird_y), .pipe_x_flat(pipe_x_flat), .gap_top_flat(gap_top_flat),
    .score(score), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic [8:0]  y;
    logic [43:0] px;
    logic [35:0] gt;
    logic [7:0]  sc;
    logic        go;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_pop;
  int   n_checks = 0, n_errors = 0;
  bit   tick_d;
  bit   saw_dying = 1'b0;

  // model state
  int         m_st, m_y, m_vel, m_sc;
  int         m_px[4], m_gt[4];
  logic [7:0] m_lfsr;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset)
    if (!reset) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  function automatic void model_init();
    m_st = 0; m_y = 200; m_vel = 0; m_sc = 0;
    for (int i = 0; i < 4; i++) begin
      m_px[i] = 640 + 160*i;
      m_gt[i] = 40 + 20*i;
    end
  endfunction

  function automatic void play_step(input bit flap);
    int  ys, old;
    bit  resp, rsp;
    m_vel = flap ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
    ys    = m_y + m_vel;
    resp  = 0;
    for (int i = 0; i < 4; i++) begin
      old = m_px[i];
      rsp = 0;
      if (old < 1) begin
        if (!resp) begin
          m_px[i] = old + 639;
          m_gt[i] = 40 + int'(m_lfsr[6:0]);
          resp = 1; rsp = 1;
        end
      end else m_px[i] = old - 1;
      if (!rsp && old + 50 >= 100 && m_px[i] + 50 < 100 && m_sc < 255) m_sc++;
    end
    if (ys + 30 >= 460) begin
      m_y = 430; m_st = 3;
    end else begin
      m_y = (ys < 0) ? 0 : ys;
      for (int i = 0; i < 4; i++)
        if (m_px[i] <= 130 && m_px[i] + 50 >= 100 && (m_y < m_gt[i] || m_y + 30 > m_gt[i] + 100))
          m_st = 2;
    end
  endfunction

  function automatic void model_step(input bit flap);
    int ys;
    case (m_st)
      0: if (flap) begin m_st = 1; play_step(1'b1); end
      1: play_step(flap);
      2: begin
        m_vel = (m_vel + 1 > 10) ? 10 : m_vel + 1;
        ys = m_y + m_vel;
        if (ys + 30 >= 460) begin m_y = 430; m_st = 3; end
        else m_y = (ys < 0) ? 0 : ys;
      end
      default: if (flap) model_init();
    endcase
  endfunction

  function automatic exp_t model_pack();
    exp_t e;
    e.st = 2'(m_st); e.y = 9'(m_y); e.sc = 8'(m_sc); e.go = (m_st == 3);
    e.px = '0; e.gt = '0;
    for (int i = 0; i < 4; i++) begin
      e.px[11*i +: 11] = 11'(m_px[i]);
      e.gt[9*i +: 9]   = 9'(m_gt[i]);
    end
    return e;
  endfunction

  task automatic press_flap();
    @(negedge clk) flap_btn = 1'b1;
    repeat (4) @(negedge clk);
    flap_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_tick(input bit flap);
    if (flap) press_flap();
    @(negedge clk);
    model_step(flap);
    sb_q.push_back(model_pack());
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  always @(posedge clk or negedge reset)
    if (!reset) tick_d <= 1'b0;
    else        tick_d <= frame_tick;

  // scoreboard consumer: compares the frame that just committed
  always @(negedge clk) begin
    if (state == 2'd2) saw_dying <= 1'b1;
    if (tick_d) begin
      if (sb_q.size() == 0) chk("sb_empty", 64'd0, 64'd1);
      else begin
        e_pop = sb_q.pop_front();
        chk("state",     64'(state),        64'(e_pop.st));
        chk("bird_y",    64'(bird_y),       64'(e_pop.y));
        chk("pipe_x",    64'(pipe_x_flat),  64'(e_pop.px));
        chk("gap_top",   64'(gap_top_flat), 64'(e_pop.gt));
        chk("score",     64'(score),        64'(e_pop.sc));
        chk("game_over", 64'(game_over),    64'(e_pop.go));
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int y_a, tgt, best, prev_px0, gt0, n;
    bit fl, passed_chk;
    model_init();
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_y", 64'(bird_y), 64'd200);
    chk("rst_px", 64'(pipe_x_flat), 64'({11'd1120, 11'd960, 11'd800, 11'd640}));
    chk("rst_gt", 64'(gap_top_flat), 64'({9'd100, 9'd80, 9'd60, 9'd40}));
    chk("rst_score", 64'(score), 64'd0);
    chk("rst_go", 64'(game_over), 64'd0);
    @(negedge clk) reset = 1'b1;

    // idle tick without flap, then start
    do_tick(1'b0);
    chk("idle_hold", 64'(state), 64'd0);
    do_tick(1'b1);
    chk("start_state", 64'(state), 64'd1);
    chk("start_y", 64'(bird_y), 64'd192);
    do_tick(1'b0);
    chk("second_y", 64'(bird_y), 64'd185);
    repeat (17) do_tick(1'b0);
    chk("y_at_sat", 64'(bird_y), 64'd219);
    y_a = int'(bird_y);
    do_tick(1'b0);
    chk("vel_sat", 64'(int'(bird_y) - y_a), 64'd10);

    // free fall to the ground
    n = 0;
    while (m_st != 3 && n < 100) begin do_tick(1'b0); n++; end
    chk("ground_y", 64'(bird_y), 64'd430);
    chk("ground_state", 64'(state), 64'd3);
    chk("ground_go", 64'(game_over), 64'd1);
    do_tick(1'b0);
    chk("over_frozen", 64'(state), 64'd3);
    do_tick(1'b1);
    chk("reinit_state", 64'(state), 64'd0);
    chk("reinit_y", 64'(bird_y), 64'd200);
    chk("reinit_score", 64'(score), 64'd0);

    // second game: steer through gaps until pipe 0 passes and respawns
    do_tick(1'b1);
    passed_chk = 0;
    n = 0;
    while (m_st == 1 && n < 1500) begin
      best = -1;
      for (int i = 0; i < 4; i++)
        if (m_px[i] + 50 >= 100 && (best < 0 || m_px[i] < m_px[best])) best = i;
      tgt = m_gt[best] + 55;
      fl = (m_y > tgt) && (m_vel >= 0);
      prev_px0 = m_px[0];
      do_tick(fl);
      n++;
      if (prev_px0 == 50) begin
        chk("pass_px0", 64'(pipe_x_flat[10:0]), 64'd49);
        chk("pass_score", 64'(score), 64'd1);
        passed_chk = 1;
      end
      if (prev_px0 == 0) begin
        chk("respawn_px0", 64'(pipe_x_flat[10:0]), 64'd639);
        gt0 = int'(gap_top_flat[8:0]);
        chk("respawn_gt_rng", 64'(gt0 >= 40 && gt0 <= 167), 64'd1);
        break;
      end
    end
    chk("pass_seen", 64'(passed_chk), 64'd1);

    // stop flapping: pipe 1 hits the falling bird, then it drops to the ground
    n = 0;
    while (m_st != 3 && n < 300) begin do_tick(1'b0); n++; end
    chk("saw_dying", 64'(saw_dying), 64'd1);
    chk("dying_end_y", 64'(bird_y), 64'd430);
    chk("dying_end_state", 64'(state), 64'd3);
    chk("dying_score", 64'(score), 64'd1);

    // mid-play reset between clock edges
    do_tick(1'b1);
    do_tick(1'b1);
    repeat (3) do_tick(1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_state", 64'(state), 64'd0);
    chk("mid_rst_y", 64'(bird_y), 64'd200);
    chk("mid_rst_px", 64'(pipe_x_flat), 64'({11'd1120, 11'd960, 11'd800, 11'd640}));
    chk("mid_rst_score", 64'(score), 64'd0);
    model_init();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    // flap edge arriving on the same cycle as the tick
    flap_btn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    model_step(1'b1);
    sb_q.push_back(model_pack());
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    flap_btn   = 1'b0;
    chk("coinc_state", 64'(state), 64'd1);
    chk("coinc_y", 64'(bird_y), 64'd192);
    repeat (6) @(negedge clk);
    do_tick(1'b0);
    chk("coinc_next_y", 64'(bird_y), 64'd185);

    repeat (2) @(negedge clk);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
